// File: rtl/fifo_buffer_pkg.sv
// Shared constants and helpers for fifo_buffer and its producers/consumers.
// Defaults here keep fifo_switch users and this block sized consistently.
package fifo_buffer_pkg;

  localparam int unsigned FIFO_DEFAULT_DEPTH      = 16;
  localparam int unsigned FIFO_DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned STAT_CNT_WIDTH          = 32;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned fifo_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_buffer_if.sv
// ap_fifo write side (i_*) and read side (o_*) bundled as one interface.
// master = surrounding producer/consumer, slave = the FIFO itself.
interface fifo_buffer_if
  import fifo_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] i_din;
  logic                  i_full_n;
  logic                  i_write;
  logic [DATA_WIDTH-1:0] o_dout;
  logic                  o_empty_n;
  logic                  o_read;

  modport master (
    output i_din, i_write, o_read,
    input  i_full_n, o_dout, o_empty_n
  );

  modport slave (
    input  i_din, i_write, o_read,
    output i_full_n, o_dout, o_empty_n
  );

endinterface

// File: rtl/fifo_buffer_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, no reset.
// Kept separate so it can be swapped for a LUTRAM/BRAM macro.
module fifo_buffer_ram
  import fifo_buffer_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH,
  parameter  int unsigned DEPTH      = FIFO_DEFAULT_DEPTH,
  localparam int unsigned ADDR_WIDTH = fifo_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_buffer.sv
// Synchronous FWFT FIFO between fifo_switch (ap_fifo write) and an HLS kernel (ap_fifo read).
// Define FIFO_BUFFER_STATS_EN to add stat_max_level / stat_stall_cnt outputs.
module fifo_buffer
  import fifo_buffer_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = FIFO_DEFAULT_DATA_WIDTH,
  parameter  int unsigned DEPTH      = FIFO_DEFAULT_DEPTH,
  localparam int unsigned ADDR_WIDTH = fifo_clog2(DEPTH),
  localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  fifo_buffer_if.slave              fifo,
`ifdef FIFO_BUFFER_STATS_EN
  output logic [PTR_WIDTH-1:0]      stat_max_level,
  output logic [STAT_CNT_WIDTH-1:0] stat_stall_cnt,
`endif
  output logic [PTR_WIDTH-1:0]      level
);

  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]  level_q, level_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  wr_en_c, rd_en_c;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags and level come from next-state pointers so they are plain registers.
  always_comb begin
    wr_en_c   = fifo.i_write && full_n_q;
    rd_en_c   = fifo.o_read && empty_n_q;
    wr_ptr_d  = wr_ptr_q + PTR_WIDTH'(wr_en_c);
    rd_ptr_d  = rd_ptr_q + PTR_WIDTH'(rd_en_c);
    level_d   = wr_ptr_d - rd_ptr_d;
    empty_n_d = (wr_ptr_d != rd_ptr_d);
    full_n_d  = !((wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]));
  end

  // full_n is held low in reset so the producer waits one cycle after release.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_n_q  <= 1'b0;
      empty_n_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

  fifo_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (ap_clk),
    .we    (wr_en_c && !ap_rst),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (fifo.i_din),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  assign fifo.i_full_n  = full_n_q;
  assign fifo.o_empty_n = empty_n_q;
  assign fifo.o_dout    = empty_n_q ? ram_rdata : '0;
  assign level          = level_q;

`ifdef FIFO_BUFFER_STATS_EN
  logic [PTR_WIDTH-1:0]      max_level_q, max_level_d;
  logic [STAT_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // High-water mark trails level by a cycle; stall counter saturates.
  always_comb begin
    max_level_d = max_level_q;
    stall_cnt_d = stall_cnt_q;
    if (level_q > max_level_q) max_level_d = level_q;
    if (fifo.i_write && !full_n_q && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STAT_CNT_WIDTH'(1);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      max_level_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      max_level_q <= max_level_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_max_level = max_level_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
